gpio_hex_display: RTL and testbench

//  Output-side endpoint of the CPU GPIO port. Captures every 32-bit word the CPU

---
 rtl/gpio_disp_pkg.sv | 33 +++
 rtl/hex_digit_mux.sv | 26 ++
 rtl/gpio_hex_display.sv | 100 ++++++++++
 tb/tb_gpio_hex_display.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_disp_pkg.sv
// Shared constants and the hex-to-7-segment encoder for the GPIO hex display.
package gpio_disp_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic seg_t hex7seg(input nibble_t nib);
    seg_t s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_digit_mux.sv
// Selects the nibble for the scanned digit, applies leading-zero blanking and
// encodes it for the 7-segment display.
module hex_digit_mux
  import gpio_disp_pkg::*;
#(
  parameter int unsigned DIG_W      = 3,
  parameter int unsigned BLANK_LEAD = 1
) (
  input  logic [31:0]      value,
  input  logic [DIG_W-1:0] digit,
  output logic [6:0]       seg
);

  logic [31:0] upper;

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    upper = value >> {digit, 2'b00};
    if (BLANK_LEAD != 0 && digit != '0 && upper == '0) begin
      seg = SEG_OFF;
    end else begin
      seg = hex7seg(upper[3:0]);
    end
  end

endmodule

// File: rtl/gpio_hex_display.sv
// GPIO output endpoint: latches CPU writes and scans them onto a multiplexed
// common-anode 7-segment display with frame-synchronous double buffering.
module gpio_hex_display
  import gpio_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned BLANK_LEAD  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gpio_we,
  input  logic [31:0]           gpio_out,
  input  logic                  disp_en,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [31:0]           shown_value,
  output logic                  pending
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]      div_cnt;
  logic [DIG_W-1:0]      digit;
  logic [31:0]           shadow;
  logic [31:0]           front;
  logic                  pend_q;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic                  wrap;
  logic                  swap;
  logic                  slot_off;
  logic [6:0]            digit_seg;
  logic [6:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  hex_digit_mux #(
    .DIG_W      (DIG_W),
    .BLANK_LEAD (BLANK_LEAD)
  ) u_mux (
    .value (front),
    .digit (digit),
    .seg   (digit_seg)
  );

  always_comb begin
    wrap     = (div_cnt == DIV_W'(REFRESH_DIV - 1));
    swap     = wrap && (digit == DIG_W'(NUM_DIGITS - 1));
    slot_off = (div_cnt < DIV_W'(GUARD)) || !disp_en;
    an_d     = '1;
    seg_d    = SEG_OFF;
    if (!slot_off) begin
      an_d  = ~(NUM_DIGITS'(1) << digit);
      seg_d = digit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      digit   <= '0;
      shadow  <= '0;
      front   <= '0;
      pend_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= '1;
    end else begin
      if (wrap) begin
        div_cnt <= '0;
        digit   <= (digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // A write landing on the swap edge is held for the next frame:
      // front takes the old shadow while pending is re-armed by the write.
      if (swap && pend_q) begin
        front <= shadow;
      end
      if (gpio_we) begin
        shadow <= gpio_out;
        pend_q <= 1'b1;
      end else if (swap) begin
        pend_q <= 1'b0;
      end

      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign shown_value = front;
  assign pending     = pend_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// Self-checking bench for gpio_hex_display: directed scenarios plus random
// traffic, compared every cycle against a frame/slot arithmetic model.
module tb_gpio_hex_display;

  localparam int RD    = 4;
  localparam int GRD   = 1;
  localparam int ND    = 8;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gpio_we = 1'b0;
  logic [31:0] gpio_out = '0;
  logic        disp_en = 1'b1;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [31:0] shown_value;
  logic        pending;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          t = 0;
  logic [31:0] m_shadow = '0;
  logic [31:0] m_front = '0;
  logic        m_pending = 1'b0;
  logic [6:0]  m_seg = 7'h7F;
  logic [7:0]  m_an = 8'hFF;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  gpio_hex_display #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD       (GRD),
    .BLANK_LEAD  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_we     (gpio_we),
    .gpio_out    (gpio_out),
    .disp_en     (disp_en),
    .seg         (seg),
    .an          (an),
    .shown_value (shown_value),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(int dig, logic [31:0] f);
    logic [31:0] up;
    logic [3:0]  nib;
    up  = f >> (4 * dig);
    nib = up[3:0];
    if (dig != 0 && up == 0) return 7'h7F;
    return tbl[nib];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // One clock: advance the model from the pre-edge state and inputs, then
  // compare every output just after the edge.
  task automatic step();
    int          phase;
    int          dig;
    bit          swap;
    logic [31:0] old_shadow;
    logic        old_pending;
    if (rst) begin
      t = 0;
      m_shadow = '0;
      m_front = '0;
      m_pending = 1'b0;
      m_seg = 7'h7F;
      m_an = 8'hFF;
    end else begin
      phase = t % RD;
      dig   = (t / RD) % ND;
      if (phase < GRD || !disp_en) begin
        m_an  = 8'hFF;
        m_seg = 7'h7F;
      end else begin
        m_an  = ~(8'd1 << dig);
        m_seg = model_seg(dig, m_front);
      end
      swap        = (t % FRAME) == FRAME - 1;
      old_shadow  = m_shadow;
      old_pending = m_pending;
      if (swap && old_pending) begin
        m_front   = old_shadow;
        m_pending = 1'b0;
      end
      if (gpio_we) begin
        m_shadow  = gpio_out;
        m_pending = 1'b1;
      end
      t++;
    end
    @(posedge clk);
    #1;
    chk("seg", 32'(seg), 32'(m_seg));
    chk("an", 32'(an), 32'(m_an));
    chk("shown_value", shown_value, m_front);
    chk("pending", 32'(pending), 32'(m_pending));
    chk("an_onehot0", 32'($onehot0(~an)), 32'd1);
  endtask

  task automatic run_to(int ph);
    gpio_we = 1'b0;
    while ((t % FRAME) != ph) step();
  endtask

  task automatic write_step(logic [31:0] d);
    gpio_we  = 1'b1;
    gpio_out = d;
    step();
    gpio_we  = 1'b0;
  endtask

  initial begin
    // 1: reset, then an idle frame showing a lone "0" on digit 0
    rst = 1'b1;
    repeat (3) step();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_shown", shown_value, 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    repeat (GRD + 1) step();
    chk("first_lit_an", 32'(an), 32'hFE);
    chk("first_lit_seg", 32'(seg), 32'h40);
    repeat (FRAME) step();

    // 2: mid-frame write waits for the frame boundary
    run_to(10);
    write_step(32'h1234_ABCD);
    chk("mid_pending", 32'(pending), 32'h1);
    chk("mid_shown_hold", shown_value, 32'h0);
    run_to(0);
    chk("swap_shown", shown_value, 32'h1234_ABCD);
    chk("swap_pending", 32'(pending), 32'h0);
    repeat (2) step();
    chk("d0_seg", 32'(seg), 32'h21);
    repeat (7 * RD) step();
    chk("d7_an", 32'(an), 32'h7F);
    chk("d7_seg", 32'(seg), 32'h79);

    // 3: leading-zero blanking
    write_step(32'h0000_00F0);
    run_to(0);
    repeat (FRAME) step();
    chk("lz_shown", shown_value, 32'h0000_00F0);

    // 4: back-to-back writes, then one on the swap edge
    run_to(FRAME - 4);
    step();
    write_step(32'h0000_000A);
    write_step(32'h0000_000B);
    write_step(32'h0000_000C);
    chk("b2b_front_B", shown_value, 32'h0000_000B);
    chk("b2b_pending", 32'(pending), 32'h1);
    run_to(FRAME - 1);
    chk("b2b_still_pending", 32'(pending), 32'h1);
    step();
    chk("b2b_front_C", shown_value, 32'h0000_000C);
    chk("b2b_cleared", 32'(pending), 32'h0);

    // 5: display disabled for a frame; swap still happens
    disp_en = 1'b0;
    write_step(32'hDEAD_BEEF);
    repeat (FRAME) begin
      step();
      chk("dis_an", 32'(an), 32'hFF);
    end
    disp_en = 1'b1;
    chk("dis_shown", shown_value, 32'hDEAD_BEEF);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      gpio_we  = ($urandom_range(0, 7) == 0);
      gpio_out = $urandom();
      disp_en  = ($urandom_range(0, 9) != 0);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    gpio_we = 1'b0;
    rst     = 1'b0;
    disp_en = 1'b1;

    // 6: reset mid-slot with a write pending
    run_to(5);
    write_step(32'h5A5A_0001);
    run_to(10);
    chk("pre_rst_pending", 32'(pending), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_an", 32'(an), 32'hFF);
    chk("mid_rst_shown", shown_value, 32'h0);
    chk("mid_rst_pending", 32'(pending), 32'h0);
    repeat (2 * FRAME) step();
    chk("post_rst_shown", shown_value, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
